// File: rtl/timer_if.sv
// Board-side inputs and datapath-side outputs of the countdown timer controller.
interface timer_if;
  logic        dip_sw;
  logic [9:0]  keypad;
  logic        key_start;
  logic        key_clear;
  logic        cnt_zero;
  logic [23:0] digit_buf;
  logic [2:0]  digit_idx;
  logic        load;
  logic        run_en;
  logic        tick;
  logic        alarm;
  logic        blink;
  logic        err;
  logic [2:0]  state;

  modport master (
    output dip_sw, keypad, key_start, key_clear, cnt_zero,
    input  digit_buf, digit_idx, load, run_en, tick, alarm, blink, err, state
  );

  modport slave (
    input  dip_sw, keypad, key_start, key_clear, cnt_zero,
    output digit_buf, digit_idx, load, run_en, tick, alarm, blink, err, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown timer control FSM: HH:MM:SS keypad entry, load/run/pause sequencing,
// 1 s tick generation and a timed blinking alarm.
module timer_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int BLINK_DIV = 250,
  parameter int ALARM_CYC = 5000
) (
  input  logic    clk,
  input  logic    rst,
  timer_if.slave  tif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int AW = $clog2(ALARM_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_ALARM = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   buf_q, buf_d;
  logic [2:0]    idx_q, idx_d;
  logic          load_q, load_d, run_en_q, run_en_d, tick_q, tick_d;
  logic          alarm_q, alarm_d, blink_q, blink_d, err_q, err_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [9:0]    key_prev_q;
  logic          start_prev_q, clear_prev_q;

  logic       dig_ev, start_ev, clear_ev;
  logic [3:0] dval;

  assign dig_ev   = $onehot(tif.keypad) && (key_prev_q == 10'd0);
  assign start_ev = tif.key_start & ~start_prev_q;
  assign clear_ev = tif.key_clear & ~clear_prev_q;

  always_comb begin
    dval = 4'd0;
    for (int i = 0; i < 10; i++)
      if (tif.keypad[i]) dval = 4'(i);
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    load_d   = 1'b0;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    run_en_d = run_en_q;
    alarm_d  = alarm_q;
    blink_d  = blink_q;
    presc_d  = presc_q;
    bcnt_d   = bcnt_q;
    acnt_d   = acnt_q;

    if (!tif.dip_sw) begin
      state_d  = S_IDLE;
      buf_d    = '0;
      idx_d    = '0;
      run_en_d = 1'b0;
      alarm_d  = 1'b0;
      blink_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ENTRY;
        S_ENTRY: begin
          if (clear_ev) begin
            buf_d = '0;
            idx_d = '0;
          end else if (dig_ev) begin
            // Tens of minutes and tens of seconds only go up to 5.
            if ((idx_q == 3'd2 || idx_q == 3'd4) && dval > 4'd5) begin
              err_d = 1'b1;
            end else begin
              buf_d[4*(5-int'(idx_q)) +: 4] = dval;
              if (idx_q == 3'd5) begin
                idx_d   = '0;
                state_d = S_READY;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
          end
        end
        S_READY: begin
          if (clear_ev) begin
            state_d = S_ENTRY;
            buf_d   = '0;
            idx_d   = '0;
          end else if (start_ev) begin
            if (buf_q != 24'd0) begin
              state_d  = S_RUN;
              load_d   = 1'b1;
              run_en_d = 1'b1;
              presc_d  = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          // cnt_zero is stale during the load cycle, so it is ignored there.
          if (clear_ev) begin
            state_d  = S_ENTRY;
            buf_d    = '0;
            idx_d    = '0;
            run_en_d = 1'b0;
          end else if (tif.cnt_zero && !load_q) begin
            state_d  = S_ALARM;
            run_en_d = 1'b0;
            alarm_d  = 1'b1;
            blink_d  = 1'b1;
            bcnt_d   = '0;
            acnt_d   = '0;
          end else if (start_ev) begin
            state_d  = S_PAUSE;
            run_en_d = 1'b0;
          end else if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (clear_ev) begin
            state_d = S_ENTRY;
            buf_d   = '0;
            idx_d   = '0;
          end else if (start_ev) begin
            state_d  = S_RUN;
            run_en_d = 1'b1;
          end
        end
        S_ALARM: begin
          if (clear_ev || start_ev || dig_ev || acnt_q == AW'(ALARM_CYC - 1)) begin
            state_d = S_IDLE;
            buf_d   = '0;
            idx_d   = '0;
            alarm_d = 1'b0;
            blink_d = 1'b0;
          end else begin
            acnt_d = acnt_q + AW'(1);
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
              bcnt_d  = '0;
              blink_d = ~blink_q;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      idx_q        <= '0;
      load_q       <= 1'b0;
      run_en_q     <= 1'b0;
      tick_q       <= 1'b0;
      alarm_q      <= 1'b0;
      blink_q      <= 1'b0;
      err_q        <= 1'b0;
      presc_q      <= '0;
      bcnt_q       <= '0;
      acnt_q       <= '0;
      key_prev_q   <= '0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      load_q       <= load_d;
      run_en_q     <= run_en_d;
      tick_q       <= tick_d;
      alarm_q      <= alarm_d;
      blink_q      <= blink_d;
      err_q        <= err_d;
      presc_q      <= presc_d;
      bcnt_q       <= bcnt_d;
      acnt_q       <= acnt_d;
      key_prev_q   <= tif.keypad;
      start_prev_q <= tif.key_start;
      clear_prev_q <= tif.key_clear;
    end
  end

  assign tif.state     = state_q;
  assign tif.digit_buf = buf_q;
  assign tif.digit_idx = idx_q;
  assign tif.load      = load_q;
  assign tif.run_en    = run_en_q;
  assign tif.tick      = tick_q;
  assign tif.alarm     = alarm_q;
  assign tif.blink     = blink_q;
  assign tif.err       = err_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a cycle-count based reference model.
module tb_timer_ctrl;
  localparam int TICK_DIV  = 1000;
  localparam int BLINK_DIV = 250;
  localparam int ALARM_CYC = 5000;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_READY = 2, M_RUN = 3, M_PAUSE = 4, M_ALARM = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  timer_if tif();

  timer_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .ALARM_CYC(ALARM_CYC)) dut (
    .clk(clk), .rst(rst), .tif(tif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed-cycle counters instead of the RTL's prescalers.
  int         m_st, m_idx, m_runcyc, m_elap;
  int         m_dig[6];
  bit         m_load, m_tick, m_err;
  logic [9:0] m_kp;
  bit         m_sp, m_cp;

  task automatic clear_buf();
    foreach (m_dig[i]) m_dig[i] = 0;
    m_idx = 0;
  endtask

  task automatic model_reset();
    m_st = M_IDLE; clear_buf();
    m_load = 0; m_tick = 0; m_err = 0;
    m_runcyc = 0; m_elap = 0;
    m_kp = '0; m_sp = 0; m_cp = 0;
  endtask

  task automatic model_step();
    bit dig_ev, st_ev, cl_ev, was_load, nz;
    int d;
    dig_ev = ($countones(tif.keypad) == 1) && (m_kp == 10'd0);
    st_ev  = tif.key_start && !m_sp;
    cl_ev  = tif.key_clear && !m_cp;
    d = 0;
    for (int i = 0; i < 10; i++) if (tif.keypad[i]) d = i;
    nz = 0;
    foreach (m_dig[i]) if (m_dig[i] != 0) nz = 1;
    was_load = m_load;
    m_load = 0; m_tick = 0; m_err = 0;
    if (!tif.dip_sw) begin
      m_st = M_IDLE; clear_buf();
    end else begin
      case (m_st)
        M_IDLE: m_st = M_ENTRY;
        M_ENTRY:
          if (cl_ev) clear_buf();
          else if (dig_ev) begin
            if ((m_idx == 2 || m_idx == 4) && d > 5) m_err = 1;
            else begin
              m_dig[m_idx] = d;
              if (m_idx == 5) begin m_idx = 0; m_st = M_READY; end
              else m_idx++;
            end
          end
        M_READY:
          if (cl_ev) begin clear_buf(); m_st = M_ENTRY; end
          else if (st_ev) begin
            if (nz) begin m_load = 1; m_runcyc = 0; m_st = M_RUN; end
            else m_err = 1;
          end
        M_RUN:
          if (cl_ev) begin clear_buf(); m_st = M_ENTRY; end
          else if (tif.cnt_zero && !was_load) begin m_st = M_ALARM; m_elap = 0; end
          else if (st_ev) m_st = M_PAUSE;
          else begin
            m_runcyc++;
            m_tick = (m_runcyc % TICK_DIV) == 0;
          end
        M_PAUSE:
          if (cl_ev) begin clear_buf(); m_st = M_ENTRY; end
          else if (st_ev) m_st = M_RUN;
        M_ALARM:
          if (cl_ev || st_ev || dig_ev || m_elap == ALARM_CYC - 1) begin
            m_st = M_IDLE; clear_buf();
          end else m_elap++;
        default: m_st = M_IDLE;
      endcase
    end
    m_kp = tif.keypad; m_sp = tif.key_start; m_cp = tif.key_clear;
  endtask

  function automatic logic [35:0] model_outs();
    logic [23:0] b;
    bit blink;
    for (int i = 0; i < 6; i++) b[4*(5-i) +: 4] = 4'(m_dig[i]);
    blink = (m_st == M_ALARM) && (((m_elap / BLINK_DIV) % 2) == 0);
    return {3'(m_st), b, 3'(m_idx), m_load, (m_st == M_RUN), m_tick,
            (m_st == M_ALARM), blink, m_err};
  endfunction

  function automatic logic [35:0] dut_outs();
    return {tif.state, tif.digit_buf, tif.digit_idx, tif.load, tif.run_en, tif.tick,
            tif.alarm, tif.blink, tif.err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    chk("cycle", dut_outs(), model_outs());
  endtask

  task automatic press(input int d, output bit e);
    tif.keypad = 10'(1 << d);
    cyc();
    e = tif.err;
    tif.keypad = '0;
    cyc();
  endtask

  task automatic enter(input logic [23:0] v);
    bit e;
    for (int i = 0; i < 6; i++) press(int'(v[4*(5-i) +: 4]), e);
  endtask

  task automatic pulse_start();
    tif.key_start = 1'b1; cyc(); tif.key_start = 1'b0; cyc();
  endtask

  task automatic pulse_clear();
    tif.key_clear = 1'b1; cyc(); tif.key_clear = 1'b0; cyc();
  endtask

  task automatic wait_tick(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin cyc(); n++; end while (!tif.tick && n < exp_n + 100);
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  initial begin
    bit e;
    int n, tk, r;
    tif.dip_sw = 1'b1; tif.keypad = '0; tif.key_start = 1'b0;
    tif.key_clear = 1'b0; tif.cnt_zero = 1'b0;
    model_reset();
    repeat (3) cyc();
    chk("rst_state", tif.state, 0);
    rst = 1'b0;
    cyc();
    chk("idle_to_entry", tif.state, 1);

    enter(24'h123456);
    chk("entry_buf", tif.digit_buf, 24'h123456);
    chk("entry_state", tif.state, 2);
    press(7, e);
    chk("ready_digit_err", e, 0);
    chk("ready_digit_buf", tif.digit_buf, 24'h123456);

    pulse_clear();
    chk("clear_to_entry", tif.state, 1);
    press(0, e); press(1, e); press(7, e);
    chk("val_err", e, 1);
    chk("val_buf", tif.digit_buf, 24'h010000);
    chk("val_idx", tif.digit_idx, 2);
    press(5, e);
    chk("val_idx5", tif.digit_idx, 3);

    pulse_clear();
    enter(24'h000003);
    tif.key_start = 1'b1; cyc(); tif.key_start = 1'b0;
    chk("load_pulse", {tif.load, tif.run_en, tif.state}, {1'b1, 1'b1, 3'd3});
    wait_tick("tick1", TICK_DIV);
    wait_tick("tick2", TICK_DIV);
    wait_tick("tick3", TICK_DIV);
    tif.cnt_zero = 1'b1; cyc(); tif.cnt_zero = 1'b0;
    chk("alarm_enter", {tif.state, tif.alarm, tif.blink, tif.run_en, tif.tick},
        {3'd5, 1'b1, 1'b1, 1'b0, 1'b0});
    n = 0;
    do begin cyc(); n++; end while (tif.blink && n < BLINK_DIV + 50);
    chk("blink_period", 64'(n), 64'(BLINK_DIV));
    do begin cyc(); n++; end while (tif.state == 3'd5 && n < ALARM_CYC + 100);
    chk("alarm_len", 64'(n), 64'(ALARM_CYC));
    chk("alarm_exit", {tif.alarm, tif.blink, tif.state}, 5'd0);

    cyc();
    enter(24'h000010);
    tif.key_start = 1'b1; cyc(); tif.key_start = 1'b0;
    repeat (400) cyc();
    tif.key_start = 1'b1; cyc(); tif.key_start = 1'b0;
    chk("pause_state", tif.state, 4);
    tk = 0;
    repeat (2000) begin cyc(); tk += int'(tif.tick); end
    chk("pause_notick", 64'(tk), 0);
    tif.key_start = 1'b1; cyc(); tif.key_start = 1'b0;
    chk("resume_state", tif.state, 3);
    wait_tick("resume_tick", TICK_DIV - 400);

    pulse_clear();
    tif.keypad = 10'b0000000010;
    repeat (50) cyc();
    tif.keypad = '0; cyc();
    chk("held_idx", tif.digit_idx, 1);
    chk("held_buf", tif.digit_buf, 24'h100000);
    tif.keypad = 10'b0000000011;
    repeat (3) cyc();
    tif.keypad = '0; cyc();
    chk("multi_idx", tif.digit_idx, 1);
    pulse_clear();
    enter(24'h000000);
    tif.key_start = 1'b1; cyc(); tif.key_start = 1'b0;
    chk("zero_start", {tif.err, tif.state, tif.load}, {1'b1, 3'd2, 1'b0});
    cyc();
    chk("err_one_cycle", tif.err, 0);

    pulse_clear();
    enter(24'h000001);
    pulse_start();
    repeat (20) cyc();
    chk("dip_run", tif.state, 3);
    tif.dip_sw = 1'b0; cyc();
    chk("dip_off", {tif.state, tif.run_en}, 4'd0);
    tif.dip_sw = 1'b1; cyc();

    enter(24'h000002);
    pulse_start();
    repeat (10) cyc();
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 64'(dut_outs()), 0);
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_release", tif.state, 1);

    for (int c = 0; c < 20000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 6)      tif.keypad = 10'(1 << $urandom_range(0, 9));
      else if (r < 8) tif.keypad = 10'($urandom_range(0, 1023));
      else            tif.keypad = '0;
      if ($urandom_range(0, 99) < 4) tif.key_start = ~tif.key_start;
      if ($urandom_range(0, 99) < 2) tif.key_clear = ~tif.key_clear;
      tif.cnt_zero = ($urandom_range(0, 999) < 3);
      tif.dip_sw   = ($urandom_range(0, 999) >= 3);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
